// File: rtl/sa_voice_addr_gen_pkg.sv
// Shared widths, CPU register encodings and the per-voice state record
// for the time-multiplexed sample address generator.
package sa_voice_pkg;

   localparam int NVOICES = 16;
   localparam int ADDR_W  = 20;
   localparam int FRAC_W  = 10;
   localparam int PITCH_W = 14;
   localparam int VOICE_W = $clog2(NVOICES);
   localparam int ACC_W   = ADDR_W + FRAC_W;

   localparam logic [1:0] REG_PITCH = 2'd0;
   localparam logic [1:0] REG_START = 2'd1;
   localparam logic [1:0] REG_END   = 2'd2;
   localparam logic [1:0] REG_LOOP  = 2'd3;

   typedef struct packed {
      logic [PITCH_W-1:0] pitch;
      logic [ADDR_W-1:0]  start_addr;
      logic [ADDR_W-1:0]  end_addr;
      logic [ADDR_W-1:0]  loop_addr;
      logic [ACC_W-1:0]   acc;
      logic               active;
   } voice_state_t;

   // Integer sample address placed in the fixed-point domain, one carry bit wide.
   function automatic logic [ACC_W:0] to_fixed(input logic [ADDR_W-1:0] a);
      return {1'b0, a, {FRAC_W{1'b0}}};
   endfunction

endpackage

// File: rtl/sa_voice_addr_gen_if.sv
// CPU control and ROM address bus of the voice address generator.
interface sa_voice_addr_gen_if;
   import sa_voice_pkg::*;

   logic               cpu_we;
   logic [VOICE_W-1:0] cpu_voice;
   logic [1:0]         cpu_reg;
   logic [ADDR_W-1:0]  cpu_data;
   logic               key_on;
   logic               key_off;
   logic [VOICE_W-1:0] slot;
   logic               frame_start;
   logic [ADDR_W-1:0]  rom_addr;
   logic [FRAC_W-1:0]  rom_frac;
   logic               addr_valid;

   modport master (
      output cpu_we, cpu_voice, cpu_reg, cpu_data, key_on, key_off,
      input  slot, frame_start, rom_addr, rom_frac, addr_valid
   );

   modport slave (
      input  cpu_we, cpu_voice, cpu_reg, cpu_data, key_on, key_off,
      output slot, frame_start, rom_addr, rom_frac, addr_valid
   );

endinterface

// File: rtl/sa_voice_state_ram.sv
// Per-voice state register file: async read of the serviced slot, an accumulator
// update port and a CPU field/key port merged as key_on > key_off > update.
module sa_voice_state_ram
   import sa_voice_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [VOICE_W-1:0] rd_idx,
   output voice_state_t       rd_data,
   input  logic               upd_we,
   input  logic [VOICE_W-1:0] upd_idx,
   input  logic [ACC_W-1:0]   upd_acc,
   input  logic               upd_active,
   input  logic               cpu_we,
   input  logic [VOICE_W-1:0] cpu_idx,
   input  logic [1:0]         cpu_reg,
   input  logic [ADDR_W-1:0]  cpu_data,
   input  logic               key_on,
   input  logic               key_off
);

   voice_state_t mem_r [NVOICES];
   voice_state_t nxt_s [NVOICES];

   assign rd_data = mem_r[rd_idx];

   // Next state of every entry; key_on restarts from the stored (pre-write) start.
   always_comb begin
      for (int i = 0; i < NVOICES; i++) begin
         nxt_s[i] = mem_r[i];
         if (key_on && (cpu_idx == VOICE_W'(i))) begin
            nxt_s[i].acc    = {mem_r[i].start_addr, {FRAC_W{1'b0}}};
            nxt_s[i].active = 1'b1;
         end else if (key_off && (cpu_idx == VOICE_W'(i))) begin
            nxt_s[i].active = 1'b0;
         end else if (upd_we && (upd_idx == VOICE_W'(i))) begin
            nxt_s[i].acc    = upd_acc;
            nxt_s[i].active = upd_active;
         end else begin
            nxt_s[i].acc    = mem_r[i].acc;
         end
         if (cpu_we && (cpu_idx == VOICE_W'(i))) begin
            case (cpu_reg)
               REG_PITCH: nxt_s[i].pitch      = cpu_data[PITCH_W-1:0];
               REG_START: nxt_s[i].start_addr = cpu_data;
               REG_END:   nxt_s[i].end_addr   = cpu_data;
               REG_LOOP:  nxt_s[i].loop_addr  = cpu_data;
               default:   nxt_s[i].pitch      = mem_r[i].pitch;
            endcase
         end else begin
            nxt_s[i].pitch = mem_r[i].pitch;
         end
      end
   end

   // Storage for all voice slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NVOICES; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NVOICES; i++) begin
            mem_r[i] <= nxt_s[i];
         end
      end
   end

endmodule

// File: rtl/sa_voice_addr_gen.sv
// Time-multiplexed per-voice sample address generator: one voice slot per clock,
// pitch accumulate with end/loop wrap, registered ROM address and fraction.
module sa_voice_addr_gen
   import sa_voice_pkg::*;
(
   input  logic               CK,
   input  logic               nCL,
   sa_voice_addr_gen_if.slave bus
);

   logic [VOICE_W-1:0] cnt_r;
   voice_state_t       cur_s;
   logic [ACC_W:0]     sum_s;
   logic [ACC_W:0]     end_fx_s;
   logic [ACC_W:0]     loop_fx_s;
   logic [ACC_W:0]     wrap_s;
   logic [ACC_W-1:0]   acc_nxt_s;
   logic               act_nxt_s;

   logic [VOICE_W-1:0] slot_r;
   logic               frame_start_r;
   logic [ADDR_W-1:0]  rom_addr_r;
   logic [FRAC_W-1:0]  rom_frac_r;
   logic               addr_valid_r;

   sa_voice_state_ram u_state (
      .clk        (CK),
      .rst_n      (nCL),
      .rd_idx     (cnt_r),
      .rd_data    (cur_s),
      .upd_we     (cur_s.active),
      .upd_idx    (cnt_r),
      .upd_acc    (acc_nxt_s),
      .upd_active (act_nxt_s),
      .cpu_we     (bus.cpu_we),
      .cpu_idx    (bus.cpu_voice),
      .cpu_reg    (bus.cpu_reg),
      .cpu_data   (bus.cpu_data),
      .key_on     (bus.key_on),
      .key_off    (bus.key_off)
   );

   // Accumulate with carry kept; clamp to loop when one wrap cannot get below end.
   always_comb begin
      sum_s     = {1'b0, cur_s.acc} + {{(ACC_W+1-PITCH_W){1'b0}}, cur_s.pitch};
      end_fx_s  = to_fixed(cur_s.end_addr);
      loop_fx_s = to_fixed(cur_s.loop_addr);
      wrap_s    = sum_s - to_fixed(cur_s.end_addr - cur_s.loop_addr);
      acc_nxt_s = sum_s[ACC_W-1:0];
      act_nxt_s = 1'b1;
      if (sum_s >= end_fx_s) begin
         if (cur_s.loop_addr == cur_s.end_addr) begin
            acc_nxt_s = end_fx_s[ACC_W-1:0];
            act_nxt_s = 1'b0;
         end else if (wrap_s >= end_fx_s) begin
            acc_nxt_s = loop_fx_s[ACC_W-1:0];
         end else begin
            acc_nxt_s = wrap_s[ACC_W-1:0];
         end
      end else begin
         acc_nxt_s = sum_s[ACC_W-1:0];
      end
   end

   // Slot counter and output registers; outputs carry the pre-add accumulator.
   always_ff @(posedge CK or negedge nCL) begin
      if (!nCL) begin
         cnt_r         <= '0;
         slot_r        <= '0;
         frame_start_r <= 1'b0;
         rom_addr_r    <= '0;
         rom_frac_r    <= '0;
         addr_valid_r  <= 1'b0;
      end else begin
         cnt_r         <= cnt_r + VOICE_W'(1);
         slot_r        <= cnt_r;
         frame_start_r <= (cnt_r == '0);
         rom_addr_r    <= cur_s.acc[ACC_W-1:FRAC_W];
         rom_frac_r    <= cur_s.acc[FRAC_W-1:0];
         addr_valid_r  <= cur_s.active;
      end
   end

   assign bus.slot        = slot_r;
   assign bus.frame_start = frame_start_r;
   assign bus.rom_addr    = rom_addr_r;
   assign bus.rom_frac    = rom_frac_r;
   assign bus.addr_valid  = addr_valid_r;

endmodule

// File: tb/tb_sa_voice_addr_gen.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// arithmetic per-voice reference model.
module tb_sa_voice_addr_gen;

   logic CK  = 1'b0;
   logic nCL = 1'b0;

   sa_voice_addr_gen_if bus ();

   sa_voice_addr_gen dut (
      .CK  (CK),
      .nCL (nCL),
      .bus (bus)
   );

   always #5 CK = ~CK;

   int n_vec = 0;
   int n_err = 0;

   longint m_pitch [16];
   longint m_start [16];
   longint m_end   [16];
   longint m_loop  [16];
   longint m_acc   [16];
   bit     m_act   [16];
   int     m_cnt;

   logic [31:0] exp_slot, exp_fs, exp_addr, exp_frac, exp_valid;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_pitch[i] = 0; m_start[i] = 0; m_end[i] = 0; m_loop[i] = 0;
         m_acc[i] = 0; m_act[i] = 1'b0;
      end
      m_cnt = 0;
      exp_slot = 32'd0; exp_fs = 32'd0; exp_addr = 32'd0; exp_frac = 32'd0; exp_valid = 32'd0;
   endtask

   // One clock of the reference: visit slot m_cnt, then apply CPU/key events.
   task automatic model_step();
      int     s = m_cnt;
      int     v = int'(bus.cpu_voice);
      longint nxt;
      longint new_acc = m_acc[s];
      bit     new_act = m_act[s];
      exp_slot  = 32'(s);
      exp_fs    = (s == 0) ? 32'd1 : 32'd0;
      exp_addr  = 32'(m_acc[s] / 1024);
      exp_frac  = 32'(m_acc[s] % 1024);
      exp_valid = m_act[s] ? 32'd1 : 32'd0;
      if (m_act[s]) begin
         nxt = m_acc[s] + m_pitch[s];
         if (nxt >= m_end[s] * 1024) begin
            if (m_loop[s] == m_end[s]) begin
               new_acc = m_end[s] * 1024;
               new_act = 1'b0;
            end else begin
               nxt = nxt - (m_end[s] - m_loop[s]) * 1024;
               new_acc = (nxt >= m_end[s] * 1024) ? m_loop[s] * 1024 : nxt;
            end
         end else begin
            new_acc = nxt;
         end
      end
      if (!((bus.key_on || bus.key_off) && v == s)) begin
         m_acc[s] = new_acc;
         m_act[s] = new_act;
      end
      if (bus.key_on) begin
         m_acc[v] = m_start[v] * 1024;
         m_act[v] = 1'b1;
      end else if (bus.key_off) begin
         m_act[v] = 1'b0;
      end
      if (bus.cpu_we) begin
         case (bus.cpu_reg)
            2'd0:    m_pitch[v] = longint'(bus.cpu_data) % 16384;
            2'd1:    m_start[v] = longint'(bus.cpu_data);
            2'd2:    m_end[v]   = longint'(bus.cpu_data);
            default: m_loop[v]  = longint'(bus.cpu_data);
         endcase
      end
      m_cnt = (s + 1) % 16;
   endtask

   task automatic tick();
      @(posedge CK);
      model_step();
      @(negedge CK);
      check_eq("slot",        32'(bus.slot),        exp_slot);
      check_eq("frame_start", 32'(bus.frame_start), exp_fs);
      check_eq("rom_addr",    32'(bus.rom_addr),    exp_addr);
      check_eq("rom_frac",    32'(bus.rom_frac),    exp_frac);
      check_eq("addr_valid",  32'(bus.addr_valid),  exp_valid);
      bus.cpu_we  = 1'b0;
      bus.key_on  = 1'b0;
      bus.key_off = 1'b0;
   endtask

   task automatic cpu_write(input int v, input int r, input int d);
      bus.cpu_we    = 1'b1;
      bus.cpu_voice = 4'(v);
      bus.cpu_reg   = 2'(r);
      bus.cpu_data  = 20'(d);
      tick();
   endtask

   task automatic key_on_voice(input int v);
      bus.key_on    = 1'b1;
      bus.cpu_voice = 4'(v);
      tick();
   endtask

   task automatic setup_voice(input int v, input int p, input int st, input int en, input int lp);
      cpu_write(v, 0, p);
      cpu_write(v, 1, st);
      cpu_write(v, 2, en);
      cpu_write(v, 3, lp);
   endtask

   task automatic run_to_slot(input int v);
      int g = 0;
      do begin
         tick();
         g++;
      end while (int'(exp_slot) != v && g < 40);
      if (g >= 40) check_eq("slot_reach", 32'(bus.slot), 32'(v));
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_slot"},  32'(bus.slot),        32'd0);
      check_eq({tag, "_fs"},    32'(bus.frame_start), 32'd0);
      check_eq({tag, "_addr"},  32'(bus.rom_addr),    32'd0);
      check_eq({tag, "_frac"},  32'(bus.rom_frac),    32'd0);
      check_eq({tag, "_valid"}, 32'(bus.addr_valid),  32'd0);
   endtask

   initial begin
      int t1_tbl [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h102, 32'h103};
      bus.cpu_we = 1'b0; bus.cpu_voice = 4'd0; bus.cpu_reg = 2'd0; bus.cpu_data = 20'd0;
      bus.key_on = 1'b0; bus.key_off = 1'b0;
      model_reset();
      #2;
      check_outputs_zero("reset");
      @(negedge CK);
      nCL = 1'b1;
      tick();
      check_eq("first_fs", 32'(bus.frame_start), 32'd1);

      // Looping voice at pitch 1.0.
      setup_voice(0, 32'h400, 32'h100, 32'h104, 32'h102);
      key_on_voice(0);
      for (int k = 0; k < 6; k++) begin
         run_to_slot(0);
         check_eq("t1_addr",  32'(bus.rom_addr),   32'(t1_tbl[k]));
         check_eq("t1_frac",  32'(bus.rom_frac),   32'd0);
         check_eq("t1_valid", 32'(bus.addr_valid), 32'd1);
      end

      // One-shot voice at pitch 0.5.
      setup_voice(1, 32'h200, 32'h0, 32'h10, 32'h10);
      key_on_voice(1);
      for (int k = 0; k < 35; k++) begin
         run_to_slot(1);
         check_eq("t2_addr",  32'(bus.rom_addr),   (k < 32) ? 32'(k / 2) : 32'h10);
         check_eq("t2_frac",  32'(bus.rom_frac),   (k < 32 && k % 2 == 1) ? 32'h200 : 32'd0);
         check_eq("t2_valid", 32'(bus.addr_valid), (k < 32) ? 32'd1 : 32'd0);
      end

      // Step larger than the loop length clamps to loop.
      setup_voice(2, 32'h3FFF, 32'h10, 32'h12, 32'h10);
      key_on_voice(2);
      for (int k = 0; k < 4; k++) begin
         run_to_slot(2);
         check_eq("t3_addr",  32'(bus.rom_addr),   32'h10);
         check_eq("t3_frac",  32'(bus.rom_frac),   32'd0);
         check_eq("t3_valid", 32'(bus.addr_valid), 32'd1);
      end

      // key_on and a pitch write colliding with the slot-5 update.
      setup_voice(5, 32'h400, 32'h50, 32'h60, 32'h58);
      key_on_voice(5);
      for (int k = 0; k < 3; k++) run_to_slot(5);
      run_to_slot(4);
      bus.key_on = 1'b1; bus.cpu_we = 1'b1; bus.cpu_voice = 4'd5;
      bus.cpu_reg = 2'd0; bus.cpu_data = 20'h800;
      tick();
      run_to_slot(5);
      check_eq("t4_restart", 32'(bus.rom_addr), 32'h50);
      check_eq("t4_frac",    32'(bus.rom_frac), 32'd0);
      run_to_slot(5);
      check_eq("t4_newpitch", 32'(bus.rom_addr), 32'h52);

      // Mid-frame asynchronous clear.
      run_to_slot(9);
      #2 nCL = 1'b0;
      #1;
      check_outputs_zero("t5_async");
      model_reset();
      @(posedge CK);
      #1;
      check_outputs_zero("t5_held");
      @(negedge CK);
      nCL = 1'b1;
      tick();
      check_eq("t5_first_fs", 32'(bus.frame_start), 32'd1);
      for (int k = 0; k < 32; k++) begin
         tick();
         check_eq("t5_inactive", 32'(bus.addr_valid), 32'd0);
      end

      // All voices, distinct pitches, randomized events over 64 frames.
      for (int v = 0; v < 16; v++) begin
         int p   = 32'h100 + v * 32'h53 + int'($urandom_range(0, 32'h20));
         int st  = int'($urandom_range(32'h100, 32'hFFFF));
         int len = int'($urandom_range(1, 32'h40));
         int en, lp;
         case ($urandom_range(0, 3))
            0:       begin en = st + len; lp = en; end
            1:       begin en = st - int'($urandom_range(0, 32'h10)); lp = en - int'($urandom_range(0, 4)); end
            default: begin en = st + len; lp = en - int'($urandom_range(1, len)); end
         endcase
         setup_voice(v, p, st, en, lp);
         key_on_voice(v);
      end
      for (int c = 0; c < 1024; c++) begin
         int r = int'($urandom_range(0, 15));
         bus.cpu_voice = 4'($urandom_range(0, 15));
         case (r)
            0:       bus.key_on = 1'b1;
            1:       bus.key_off = 1'b1;
            2:       begin bus.key_on = 1'b1; bus.key_off = 1'b1; end
            3:       begin bus.cpu_we = 1'b1; bus.cpu_reg = 2'd0; bus.cpu_data = 20'($urandom_range(0, 32'h3FFF)); end
            4:       begin bus.cpu_we = 1'b1; bus.cpu_reg = 2'd1; bus.cpu_data = 20'($urandom_range(32'h100, 32'hFFFF)); end
            5:       begin bus.key_on = 1'b1; bus.cpu_we = 1'b1; bus.cpu_reg = 2'd1; bus.cpu_data = 20'($urandom_range(32'h100, 32'hFFFF)); end
            default: bus.cpu_we = 1'b0;
         endcase
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
